nios_debug_slave_cmd_queue: RTL
===============================

Name: nios_debug_slave_cmd_queue

Overview:
- Parametrised sysclk-side successor to the fixed 2-bit-IR/38-bit debug slave sysclk path.
- Synchronises JTAG virtual-state strobes (vs_udr, vs_uir) into clk and captures ir_in/sr as command entries in a FIFO of depth DEPTH.
- Drains entries through a valid/ready handshake, emitting one-hot take_action / take_no_action pulses per IR channel and a registered jdo.
- Sits between the virtual-JTAG TCK logic and the OCI break/ocimem/trace consumers.

Parameters:
IR_W, 2, instruction register width; channel count NUM_CH = 2**IR_W
DATA_W, 38, shift-register / jdo width
DEPTH, 4, command FIFO entries; power of two, >= 2
SYNC_STAGES, 2, synchroniser flops on vs_udr/vs_uir; >= 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset, asserted asynchronously, released synchronously by the integrating level
ir_in  in  IR_W  JTAG IR value, quasi-static around strobes
sr  in  DATA_W  JTAG shift register, quasi-static after update
vs_udr  in  1  async update-DR level from TCK domain
vs_uir  in  1  async update-IR level from TCK domain
cmd_ready  in  1  consumer accepts head entry
clear_ovf  in  1  clears sticky overflow/collision flags
cmd_valid  out  1  FIFO non-empty
cmd_ir  out  IR_W  head entry IR
cmd_is_dr  out  1  head entry type: 1 = update-DR, 0 = update-IR
jdo  out  DATA_W  data of last popped DR entry, held
take_action  out  NUM_CH  one-cycle pulse, bit cmd_ir, on pop of DR entry
take_no_action  out  NUM_CH  one-cycle pulse, bit cmd_ir, on pop of IR entry
level  out  clog2(DEPTH)+1  entry count
ovf  out  1  sticky: push dropped because FIFO full
collide  out  1  sticky: udr and uir edges in same cycle

Behaviour:
- Reset (async): all synchroniser flops, edge registers, pointers and level cleared. cmd_valid, take_action, take_no_action, ovf and collide = 0. jdo = 0. FIFO contents don't-care.
- Sync: each strobe passes through SYNC_STAGES flops plus one history flop; rise = sync_out & ~hist.
- Push:
  - udr rise pushes {ir_in, sr, dr=1}.
  - uir rise pushes {ir_in, 0, dr=0}.
  - ir_in/sr are sampled in the same clk cycle the rise is detected.
- Latency: strobe sampled high at edge 0 -> entry written at edge SYNC_STAGES -> cmd_valid high after edge SYNC_STAGES (2 cycles at defaults); level increments at the same edge.
- Simultaneous udr and uir rise: only the DR entry is pushed; collide is set.
- Pop: occurs when cmd_valid & cmd_ready. At that edge:
  - pointer advances.
  - take_action[cmd_ir] (DR entry) or take_no_action[cmd_ir] (IR entry) is high for exactly the following cycle; all other bits are 0.
  - jdo loads head data for DR entries; jdo is unchanged for IR entries.
- cmd_ir and cmd_is_dr reflect the head combinationally from FIFO storage. When cmd_valid = 0 they are don't-care.
- Full with push and no pop: entry dropped, ovf set, contents and level unchanged.
- Full with push and pop in the same cycle: both occur, level stays DEPTH, no ovf.
- Empty with push and pop in the same cycle: pop is not possible (cmd_valid = 0); push proceeds normally.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. level ranges 0..DEPTH.
- clear_ovf clears ovf and collide on the next edge. If a new overflow or collision occurs in the same cycle, setting wins.
- Strobe held high for many cycles yields one push per rising edge only.
- Strobe pulses shorter than one clk period may be missed. This is a requirement on the TCK side, not detected here.
- Reset mid-operation: in-flight synchroniser state and queued entries are discarded. A strobe still high at reset release produces one push after SYNC_STAGES+1 edges (history flop reset to 0).

Test Plan:
1. Defaults, ir_in=2'b01, sr=38'h12_3456_789A, pulse vs_udr, cmd_ready=1 -> cmd_valid 2 cycles after sampling; pop; take_action=4'b0010 for one cycle; jdo=38'h12_3456_789A; level back to 0.
2. ir_in=2'b11, pulse vs_uir -> take_no_action=4'b1000 single pulse, jdo unchanged, take_action stays 0.
3. cmd_ready=0, five DR strobes with sr=1..5, DEPTH=4 -> level=4, ovf=1; then drain -> jdo sequence 1,2,3,4; clear_ovf -> ovf=0.
4. FIFO full, strobe arrives in the same cycle as a pop -> level stays 4, ovf stays 0, new entry emerges last.
5. vs_udr and vs_uir rise in the same sample cycle -> one DR entry, collide=1, level=1.
6. Assert reset_n low with 3 entries queued and a strobe in the synchroniser -> all outputs 0 immediately; after release with strobes low, cmd_valid stays 0.

Source files
------------

// File: rtl/nios_debug_slave_cmd_queue.sv
// Sysclk-side debug slave command queue: synchronises JTAG update strobes, queues
// IR/DR commands and drains them as one-hot action pulses with a held jdo word.
module nios_debug_slave_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 2 ** IR_W,
  parameter int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic              cmd_ready,
  input  logic              clear_ovf,
  output logic              cmd_valid,
  output logic [IR_W-1:0]   cmd_ir,
  output logic              cmd_is_dr,
  output logic [DATA_W-1:0] jdo,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic [LVL_W-1:0]  level,
  output logic              ovf,
  output logic              collide
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_hist, uir_hist;
  logic                   udr_rise, uir_rise;

  logic [IR_W-1:0]   mem_ir   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_dr   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, push, pop, do_push;
  logic [NUM_CH-1:0] head_onehot;
  logic [DATA_W-1:0] push_data;

  // NOTE: sequential state is always updated with <= so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_hist <= 1'b0;
      uir_hist <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_hist <= udr_sync[SYNC_STAGES-1];
      uir_hist <= uir_sync[SYNC_STAGES-1];
    end
  end

  assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_hist;
  assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_hist;

  // A colliding uir edge is dropped in favour of the DR update.
  assign push      = udr_rise | uir_rise;
  assign push_data = udr_rise ? sr : '0;
  assign full      = (level == LVL_W'(DEPTH));
  assign cmd_valid = (level != '0);
  assign pop       = cmd_valid & cmd_ready;
  assign do_push   = push & (~full | pop);

  assign cmd_ir    = mem_ir[rd_ptr];
  assign cmd_is_dr = mem_dr[rd_ptr];

  always_comb begin
    // NOTE: default before the loop keeps this purely combinational (no latch).
    head_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd_ir == IR_W'(i)) head_onehot[i] = 1'b1;
    end
  end

  // NOTE: storage has no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_ir[wr_ptr]   <= ir_in;
      mem_data[wr_ptr] <= push_data;
      mem_dr[wr_ptr]   <= udr_rise;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !do_push) level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      take_action    <= '0;
      take_no_action <= '0;
      jdo            <= '0;
    end else begin
      take_action    <= (pop &&  cmd_is_dr) ? head_onehot : '0;
      take_no_action <= (pop && !cmd_is_dr) ? head_onehot : '0;
      if (pop && cmd_is_dr) jdo <= mem_data[rd_ptr];
    end
  end

  // Setting a sticky flag takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf     <= 1'b0;
      collide <= 1'b0;
    end else begin
      ovf     <= (push & full & ~pop) | (ovf & ~clear_ovf);
      collide <= (udr_rise & uir_rise) | (collide & ~clear_ovf);
    end
  end

endmodule
